stack_mem_responder: RTL and testbench

- Synthesizable 16-bit word memory that acts as the responder on the CPU memory bus.
- The CPU drives address, write data and wr; this block returns read data and a ready strobe.
- It has a configurable wait-state FSM and a sticky fault flag.
- It replaces the behavioural memory model in simulation and is the on-chip RAM in synthesis.

---
 rtl/stack_mem_responder_if.sv | 24 ++
 rtl/stack_mem_responder.sv | 153 +++++++++++++++
 tb/tb_stack_mem_responder.sv | 305 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/stack_mem_responder_if.sv
// CPU memory bus between a bus master (CPU) and the stack_mem_responder RAM.
// The master drives the request side; the slave returns data, completion and status.
interface stack_mem_responder_if #(
    parameter int AW = 16
) ();
    logic          req;
    logic [AW-1:0] address;
    logic [15:0]   data_in;
    logic          wr;
    logic [15:0]   data_out;
    logic          ready;
    logic          fault;
    logic [15:0]   wr_count;

    modport master (
        output req, address, data_in, wr,
        input  data_out, ready, fault, wr_count
    );

    modport slave (
        input  req, address, data_in, wr,
        output data_out, ready, fault, wr_count
    );
endinterface

// File: rtl/stack_mem_responder.sv
// 16-bit word RAM responding on the CPU memory bus, with wait-state FSM and sticky fault.
// Define MEM_ROM_PROTECT_EN to write-protect the lowest ROM_WORDS words.
module stack_mem_responder #(
    parameter int AW          = 16,
    parameter int DEPTH       = 2048,
    parameter int WAIT_STATES = 0,
    parameter int ROM_WORDS   = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    stack_mem_responder_if.slave bus
);
    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t        state_reg, state_next;
    logic [3:0]    cnt_reg, cnt_next;
    logic          accept;
    logic          perform;
    logic [AW-1:0] acc_addr;
    logic [15:0]   acc_wdata;
    logic          acc_wr;
    logic          in_range;
    logic          rom_hit;
    logic          mem_we;
    logic          fault_set;
    logic [IW-1:0] mem_idx;
    logic [15:0]   data_out_reg;
    logic [15:0]   wr_count_reg;
    logic          fault_reg;
    logic [15:0]   mem [DEPTH];

    if (DEPTH > (2 ** AW) || WAIT_STATES < 0 || WAIT_STATES > 15 ||
        ROM_WORDS < 0 || ROM_WORDS > DEPTH) begin : g_bad_cfg
        $error("stack_mem_responder: illegal parameter combination");
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        accept     = 1'b0;
        perform    = 1'b0;
        case (state_reg)
            // RESP accepts a held request exactly like IDLE, giving back-to-back accesses
            S_IDLE, S_RESP: begin
                state_next = S_IDLE;
                if (bus.req) begin
                    accept = 1'b1;
                    if (WAIT_STATES == 0) begin
                        perform    = 1'b1;
                        state_next = S_RESP;
                    end else begin
                        cnt_next   = 4'(WAIT_STATES);
                        state_next = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                cnt_next = cnt_reg - 4'd1;
                if (cnt_reg == 4'd1) begin
                    perform    = 1'b1;
                    state_next = S_RESP;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= S_IDLE;
            cnt_reg   <= 4'd0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    // With no wait states the access happens on the acceptance edge, so the live bus is used.
    if (WAIT_STATES == 0) begin : g_direct
        assign acc_addr  = bus.address;
        assign acc_wdata = bus.data_in;
        assign acc_wr    = bus.wr;
    end else begin : g_latched
        logic [AW-1:0] addr_reg;
        logic [15:0]   wdata_reg;
        logic          wr_reg;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                addr_reg  <= '0;
                wdata_reg <= 16'h0000;
                wr_reg    <= 1'b0;
            end else if (accept) begin
                addr_reg  <= bus.address;
                wdata_reg <= bus.data_in;
                wr_reg    <= bus.wr;
            end
        end

        assign acc_addr  = addr_reg;
        assign acc_wdata = wdata_reg;
        assign acc_wr    = wr_reg;
    end

    assign in_range = ({1'b0, acc_addr} < (AW + 1)'(DEPTH));
    assign mem_idx  = acc_addr[IW-1:0];

`ifdef MEM_ROM_PROTECT_EN
    assign rom_hit = (acc_addr < AW'(ROM_WORDS));
`else
    assign rom_hit = 1'b0;
`endif

    assign mem_we    = perform && acc_wr && in_range && !rom_hit;
    assign fault_set = perform && (!in_range || (acc_wr && rom_hit));

    // Array is deliberately outside the reset so it maps onto block RAM and survives rst_n.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_idx] <= acc_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_out_reg <= 16'h0000;
        end else if (perform && !acc_wr) begin
            data_out_reg <= in_range ? mem[mem_idx] : 16'h0000;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_count_reg <= 16'h0000;
            fault_reg    <= 1'b0;
        end else begin
            if (mem_we) begin
                wr_count_reg <= wr_count_reg + 16'd1;
            end
            if (fault_set) begin
                fault_reg <= 1'b1;
            end
        end
    end

    assign bus.data_out = data_out_reg;
    assign bus.ready    = (state_reg == S_RESP);
    assign bus.fault    = fault_reg;
    assign bus.wr_count = wr_count_reg;

endmodule

// File: tb/tb_stack_mem_responder.sv
// Self-checking bench: one responder with no wait states (dut0) and one with three (dut3),
// checked against a transaction-level memory model.
module tb_stack_mem_responder;
    localparam int AW    = 16;
    localparam int DEPTH = 2048;
`ifdef MEM_ROM_PROTECT_EN
    localparam bit ROM_EN = 1'b1;
`else
    localparam bit ROM_EN = 1'b0;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    stack_mem_responder_if #(.AW(AW)) bus0 ();
    stack_mem_responder_if #(.AW(AW)) bus3 ();

    stack_mem_responder #(.AW(AW), .DEPTH(DEPTH), .WAIT_STATES(0), .ROM_WORDS(4)) dut0 (
        .clk(clk), .rst_n(rst_n), .bus(bus0.slave));
    stack_mem_responder #(.AW(AW), .DEPTH(DEPTH), .WAIT_STATES(3), .ROM_WORDS(4)) dut3 (
        .clk(clk), .rst_n(rst_n), .bus(bus3.slave));

    int checks = 0;
    int errors = 0;

    // Reference model: index 0 = dut0, index 1 = dut3
    logic [15:0] m_mem   [2][DEPTH];
    logic [15:0] m_dout  [2];
    logic [15:0] m_cnt   [2];
    logic        m_fault [2];

    function automatic int ws_of(input int s);
        return (s == 0) ? 0 : 3;
    endfunction

    task automatic model_reset();
        for (int s = 0; s < 2; s++) begin
            m_dout[s]  = 16'h0000;
            m_cnt[s]   = 16'h0000;
            m_fault[s] = 1'b0;
        end
    endtask

    task automatic model_access(input int s, input int addr, input logic [15:0] d, input logic w);
        if (addr >= DEPTH) begin
            m_fault[s] = 1'b1;
            if (!w) m_dout[s] = 16'h0000;
        end else if (w) begin
            if (ROM_EN && addr < 4) begin
                m_fault[s] = 1'b1;
            end else begin
                m_mem[s][addr] = d;
                m_cnt[s]       = m_cnt[s] + 16'd1;
            end
        end else begin
            m_dout[s] = m_mem[s][addr];
        end
    endtask

    task automatic drive(input int s, input logic r, input logic [15:0] a, input logic [15:0] d, input logic w);
        if (s == 0) begin
            bus0.req = r; bus0.address = a; bus0.data_in = d; bus0.wr = w;
        end else begin
            bus3.req = r; bus3.address = a; bus3.data_in = d; bus3.wr = w;
        end
    endtask

    function automatic logic get_ready(input int s);
        return (s == 0) ? bus0.ready : bus3.ready;
    endfunction
    function automatic logic [15:0] get_dout(input int s);
        return (s == 0) ? bus0.data_out : bus3.data_out;
    endfunction
    function automatic logic [15:0] get_cnt(input int s);
        return (s == 0) ? bus0.wr_count : bus3.wr_count;
    endfunction
    function automatic logic get_fault(input int s);
        return (s == 0) ? bus0.fault : bus3.fault;
    endfunction

    // One access; lat = negedges from request to ready (-1 if ready never came).
    task automatic bus_xfer(input int s, input int addr, input logic [15:0] d, input logic w,
                            input bit mangle, output int lat, output logic [15:0] rd);
        logic [15:0] a16;
        a16 = addr[15:0];
        lat = -1;
        rd  = 16'hxxxx;
        @(negedge clk);
        drive(s, 1'b1, a16, d, w);
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            if (get_ready(s)) begin
                lat = n;
                rd  = get_dout(s);
                break;
            end
            if (mangle) drive(s, 1'b1, 16'($urandom), 16'($urandom), 1'($urandom));
        end
        drive(s, 1'b0, 16'h0000, 16'h0000, 1'b0);
        $display("xfer dut%0d %s addr=%0d wdata=%h lat=%0d data_out=%h wr_count=%h fault=%b",
                 ws_of(s), w ? "WR" : "RD", addr, d, lat, rd, get_cnt(s), get_fault(s));
    endtask

    task automatic test_reset();
        int lat;
        logic [15:0] rd;
        drive(0, 1'b0, 16'h0000, 16'h0000, 1'b0);
        drive(1, 1'b0, 16'h0000, 16'h0000, 1'b0);
        rst_n = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            checks++; if (get_ready(s) !== 1'b0) begin errors++; $display("FAIL reset_ready dut%0d got=%b exp=0", ws_of(s), get_ready(s)); end
            checks++; if (get_dout(s) !== 16'h0000) begin errors++; $display("FAIL reset_dout dut%0d got=%h exp=0000", ws_of(s), get_dout(s)); end
            checks++; if (get_fault(s) !== 1'b0) begin errors++; $display("FAIL reset_fault dut%0d got=%b exp=0", ws_of(s), get_fault(s)); end
            checks++; if (get_cnt(s) !== 16'h0000) begin errors++; $display("FAIL reset_wr_count dut%0d got=%h exp=0000", ws_of(s), get_cnt(s)); end
        end
        rst_n = 1'b1;
        bus_xfer(1, 5, 16'h0ABC, 1'b1, 1'b0, lat, rd);
        model_access(1, 5, 16'h0ABC, 1'b1);
        // Start a write, then reset while it is still waiting
        @(negedge clk);
        drive(1, 1'b1, 16'd5, 16'h1234, 1'b1);
        @(negedge clk);
        rst_n = 1'b0;
        drive(1, 1'b0, 16'h0000, 16'h0000, 1'b0);
        model_reset();
        @(negedge clk);
        checks++; if (bus3.ready !== 1'b0) begin errors++; $display("FAIL midwait_reset_ready got=%b exp=0", bus3.ready); end
        checks++; if (bus3.data_out !== 16'h0000) begin errors++; $display("FAIL midwait_reset_dout got=%h exp=0000", bus3.data_out); end
        @(negedge clk);
        rst_n = 1'b1;
        bus_xfer(1, 5, 16'h0000, 1'b0, 1'b0, lat, rd);
        model_access(1, 5, 16'h0000, 1'b0);
        checks++; if (rd !== m_dout[1]) begin errors++; $display("FAIL discarded_write_mem5 got=%h exp=%h", rd, m_dout[1]); end
        checks++; if (bus3.fault !== 1'b0) begin errors++; $display("FAIL after_reset_fault got=%b exp=0", bus3.fault); end
        checks++; if (bus3.wr_count !== m_cnt[1]) begin errors++; $display("FAIL after_reset_wr_count got=%h exp=%h", bus3.wr_count, m_cnt[1]); end
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        drive(0, 1'b1, 16'd3, 16'hBEEF, 1'b1);
        @(negedge clk);
        model_access(0, 3, 16'hBEEF, 1'b1);
        checks++; if (bus0.ready !== 1'b1) begin errors++; $display("FAIL b2b_write_ready got=%b exp=1", bus0.ready); end
        drive(0, 1'b1, 16'd3, 16'h0000, 1'b0);
        @(negedge clk);
        model_access(0, 3, 16'h0000, 1'b0);
        $display("xfer dut0 back-to-back WR/RD addr=3 data_out=%h wr_count=%h", bus0.data_out, bus0.wr_count);
        checks++; if (bus0.ready !== 1'b1) begin errors++; $display("FAIL b2b_read_ready got=%b exp=1", bus0.ready); end
        checks++; if (bus0.data_out !== m_dout[0]) begin errors++; $display("FAIL b2b_read_data got=%h exp=%h", bus0.data_out, m_dout[0]); end
        checks++; if (bus0.wr_count !== m_cnt[0]) begin errors++; $display("FAIL b2b_wr_count got=%h exp=%h", bus0.wr_count, m_cnt[0]); end
        drive(0, 1'b0, 16'h0000, 16'h0000, 1'b0);
        @(negedge clk);
        checks++; if (bus0.ready !== 1'b0) begin errors++; $display("FAIL b2b_ready_drop got=%b exp=0", bus0.ready); end
    endtask

    task automatic test_wait_states();
        int lat;
        logic [15:0] rd;
        bus_xfer(1, 10, 16'h00AA, 1'b1, 1'b0, lat, rd);
        model_access(1, 10, 16'h00AA, 1'b1);
        bus_xfer(1, 11, 16'h5A5A, 1'b1, 1'b0, lat, rd);
        model_access(1, 11, 16'h5A5A, 1'b1);
        // Request bus is scrambled every cycle of WAIT; only the accepted values may count
        bus_xfer(1, 10, 16'h0000, 1'b0, 1'b1, lat, rd);
        model_access(1, 10, 16'h0000, 1'b0);
        checks++; if (lat !== 4) begin errors++; $display("FAIL ws3_latency got=%0d exp=4", lat); end
        checks++; if (rd !== m_dout[1]) begin errors++; $display("FAIL ws3_read_data got=%h exp=%h", rd, m_dout[1]); end
        @(negedge clk);
        checks++; if (bus3.ready !== 1'b0) begin errors++; $display("FAIL ws3_ready_one_cycle got=%b exp=0", bus3.ready); end
        checks++; if (bus3.wr_count !== m_cnt[1]) begin errors++; $display("FAIL ws3_wr_count got=%h exp=%h", bus3.wr_count, m_cnt[1]); end
    endtask

    task automatic test_random();
        int lat, addr;
        logic [15:0] rd, d;
        logic w;
        for (int s = 0; s < 2; s++) begin
            for (int i = 0; i < 46; i++) begin
                if (i < 16) begin
                    addr = 100 + i; w = 1'b1;
                end else begin
                    addr = ($urandom_range(7, 0) == 0) ? int'($urandom_range(65535, DEPTH))
                                                       : int'($urandom_range(115, 100));
                    w = 1'($urandom);
                end
                d = 16'($urandom);
                bus_xfer(s, addr, d, w, s == 1, lat, rd);
                model_access(s, addr, d, w);
                checks++; if (lat !== ws_of(s) + 1) begin errors++; $display("FAIL rnd_latency dut%0d got=%0d exp=%0d", ws_of(s), lat, ws_of(s) + 1); end
                checks++; if (rd !== m_dout[s]) begin errors++; $display("FAIL rnd_data_out dut%0d addr=%0d got=%h exp=%h", ws_of(s), addr, rd, m_dout[s]); end
                checks++; if (get_cnt(s) !== m_cnt[s]) begin errors++; $display("FAIL rnd_wr_count dut%0d got=%h exp=%h", ws_of(s), get_cnt(s), m_cnt[s]); end
                checks++; if (get_fault(s) !== m_fault[s]) begin errors++; $display("FAIL rnd_fault dut%0d got=%b exp=%b", ws_of(s), get_fault(s), m_fault[s]); end
            end
        end
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst_n = 1'b0;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_rom_protect();
        int lat;
        logic [15:0] rd;
        pulse_reset();
        // Protected words keep whatever they held, so learn the current value first
        bus_xfer(0, 2, 16'h0000, 1'b0, 1'b0, lat, rd);
        m_mem[0][2] = rd;
        model_access(0, 2, 16'h0000, 1'b0);
        bus_xfer(0, 2, 16'h0001, 1'b1, 1'b0, lat, rd);
        model_access(0, 2, 16'h0001, 1'b1);
        bus_xfer(0, 2, 16'h7777, 1'b1, 1'b0, lat, rd);
        model_access(0, 2, 16'h7777, 1'b1);
        bus_xfer(0, 2, 16'h0000, 1'b0, 1'b0, lat, rd);
        model_access(0, 2, 16'h0000, 1'b0);
        checks++; if (lat !== 1) begin errors++; $display("FAIL rom_latency got=%0d exp=1", lat); end
        checks++; if (rd !== m_dout[0]) begin errors++; $display("FAIL rom_read_data got=%h exp=%h", rd, m_dout[0]); end
        checks++; if (bus0.fault !== m_fault[0]) begin errors++; $display("FAIL rom_fault got=%b exp=%b", bus0.fault, m_fault[0]); end
        checks++; if (bus0.wr_count !== m_cnt[0]) begin errors++; $display("FAIL rom_wr_count got=%h exp=%h", bus0.wr_count, m_cnt[0]); end
    endtask

    task automatic test_out_of_range();
        int lat;
        logic [15:0] rd;
        pulse_reset();
        bus_xfer(0, 20, 16'h1357, 1'b1, 1'b0, lat, rd);
        model_access(0, 20, 16'h1357, 1'b1);
        bus_xfer(0, 2048, 16'h5555, 1'b1, 1'b0, lat, rd);
        model_access(0, 2048, 16'h5555, 1'b1);
        checks++; if (lat !== 1) begin errors++; $display("FAIL oor_write_latency got=%0d exp=1", lat); end
        checks++; if (bus0.wr_count !== m_cnt[0]) begin errors++; $display("FAIL oor_wr_count got=%h exp=%h", bus0.wr_count, m_cnt[0]); end
        bus_xfer(0, 4000, 16'h0000, 1'b0, 1'b0, lat, rd);
        model_access(0, 4000, 16'h0000, 1'b0);
        checks++; if (lat !== 1) begin errors++; $display("FAIL oor_read_latency got=%0d exp=1", lat); end
        checks++; if (rd !== 16'h0000) begin errors++; $display("FAIL oor_read_data got=%h exp=0000", rd); end
        checks++; if (bus0.fault !== 1'b1) begin errors++; $display("FAIL oor_fault got=%b exp=1", bus0.fault); end
        bus_xfer(0, 20, 16'h0000, 1'b0, 1'b0, lat, rd);
        model_access(0, 20, 16'h0000, 1'b0);
        checks++; if (rd !== m_dout[0]) begin errors++; $display("FAIL oor_then_inrange_data got=%h exp=%h", rd, m_dout[0]); end
        checks++; if (bus0.fault !== 1'b1) begin errors++; $display("FAIL fault_sticky got=%b exp=1", bus0.fault); end
        pulse_reset();
        checks++; if (bus0.fault !== 1'b0) begin errors++; $display("FAIL fault_cleared_by_reset got=%b exp=0", bus0.fault); end
    endtask

    task automatic test_wr_count_wrap();
        int lat, done, cyc, a;
        logic [15:0] rd, d;
        pulse_reset();
        done = 0;
        cyc  = 0;
        a = int'($urandom_range(DEPTH - 1, 16));
        d = 16'($urandom);
        @(negedge clk);
        drive(0, 1'b1, a[15:0], d, 1'b1);
        while (done < 65535 && cyc < 70000) begin
            @(negedge clk);
            cyc++;
            if (bus0.ready) begin
                model_access(0, a, d, 1'b1);
                done++;
                if (done < 65535) begin
                    a = int'($urandom_range(DEPTH - 1, 16));
                    d = 16'($urandom);
                    drive(0, 1'b1, a[15:0], d, 1'b1);
                end else begin
                    drive(0, 1'b0, 16'h0000, 16'h0000, 1'b0);
                end
            end
        end
        drive(0, 1'b0, 16'h0000, 16'h0000, 1'b0);
        $display("xfer dut0 streamed %0d writes in %0d cycles wr_count=%h", done, cyc, bus0.wr_count);
        checks++; if (done !== 65535) begin errors++; $display("FAIL stream_timeout got=%0d exp=65535", done); end
        checks++; if (bus0.wr_count !== 16'hFFFF) begin errors++; $display("FAIL wr_count_full got=%h exp=ffff", bus0.wr_count); end
        bus_xfer(0, 30, 16'hC0DE, 1'b1, 1'b0, lat, rd);
        model_access(0, 30, 16'hC0DE, 1'b1);
        checks++; if (bus0.wr_count !== 16'h0000) begin errors++; $display("FAIL wr_count_wrap got=%h exp=0000", bus0.wr_count); end
        bus_xfer(0, 30, 16'h0000, 1'b0, 1'b0, lat, rd);
        model_access(0, 30, 16'h0000, 1'b0);
        checks++; if (rd !== m_dout[0]) begin errors++; $display("FAIL post_wrap_read got=%h exp=%h", rd, m_dout[0]); end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_back_to_back();
        test_wait_states();
        test_random();
        test_rom_protect();
        test_out_of_range();
        test_wr_count_wrap();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
